// File: rtl/mainfsm_pkg.sv
// Shared definitions for the multicycle main controller: state encodings,
// datapath select encodings and instruction Op field values.
package mainfsm_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  // ALUSrcA encodings
  localparam logic [1:0] SRCA_REG    = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  // ResultSrc encodings
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Op field (instruction bits 27:26)
  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

endpackage

// File: rtl/mainfsm_flopr.sv
// Resettable register with synchronous active-high reset to zero.
module mainfsm_flopr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d every edge; reset clears the register.
  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/mainfsm.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives Moore datapath selects plus raw (ungated) write requests.
module mainfsm
  import mainfsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic [3:0] State
);

  logic [3:0] state_reg;
  logic [3:0] state_next;

  // Only I and L/S bits of Funct steer sequencing; the rest belong to the decoder.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  mainfsm_flopr #(.WIDTH(4)) u_state (
    .clk   (clk),
    .reset (reset),
    .d     (state_next),
    .q     (state_reg)
  );

  assign State = state_reg;

  // Next-state: Op/Funct only matter in DECODE and MEMADR; illegal codes go to FETCH.
  always_comb begin
    state_next = FETCH;
    case (state_reg)
      FETCH:    state_next = DECODE;
      DECODE: begin
        case (Op)
          OP_MEM:  state_next = MEMADR;
          OP_DP:   state_next = Funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:   state_next = BRANCH;
          default: state_next = FETCH;
        endcase
      end
      MEMADR:   state_next = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  state_next = MEMWB;
      MEMWB:    state_next = FETCH;
      MEMWRITE: state_next = FETCH;
      EXECUTER: state_next = ALUWB;
      EXECUTEI: state_next = ALUWB;
      ALUWB:    state_next = FETCH;
      BRANCH:   state_next = FETCH;
      default:  state_next = FETCH;
    endcase
  end

  // Moore output decode: every output defaults to 0 and is set per state.
  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = SRCA_REG;
    ALUSrcB   = SRCB_REG;
    ResultSrc = RES_ALUOUT;
    ALUOp     = 1'b0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    case (state_reg)
      FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        NextPC    = 1'b1;
      end
      DECODE: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      MEMADR: begin
        ALUSrcB = SRCB_IMM;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegW      = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECUTER: begin
        ALUOp = 1'b1;
      end
      EXECUTEI: begin
        ALUSrcB = SRCB_IMM;
        ALUOp   = 1'b1;
      end
      ALUWB: begin
        RegW = 1'b1;
      end
      BRANCH: begin
        ALUSrcA   = SRCA_ALUOUT;
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        Branch    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mainfsm.sv
// Self-checking bench for mainfsm: directed table, hand sequences, random stream.
module tb_mainfsm;
  import mainfsm_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       IRWrite, AdrSrc, ALUOp, NextPC, RegW, MemW, Branch;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0] State;

  mainfsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ALUOp(ALUOp), .NextPC(NextPC), .RegW(RegW),
    .MemW(MemW), .Branch(Branch), .State(State)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       irwrite;
    logic       adrsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       aluop;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic [3:0] state;
  } outs_t;

  typedef struct {
    logic [1:0] op;
    logic [5:0] funct;
    int         len;
    logic [3:0] st[5];
  } vec_t;

  outs_t act;
  assign act = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC,
                RegW, MemW, Branch, State};

  int vectors = 0;
  int errors  = 0;
  int cyc_cnt = 0;
  int pc_cnt  = 0;
  int wr_cnt  = 0;

  // Output set required in each state, straight from the state table.
  function automatic outs_t exp_out(logic [3:0] s);
    outs_t o;
    o = '0;
    o.state = s;
    case (s)
      4'd0: begin o.irwrite = 1; o.alusrca = 2'b01; o.alusrcb = 2'b10;
                  o.resultsrc = 2'b10; o.nextpc = 1; end
      4'd1: begin o.alusrca = 2'b01; o.alusrcb = 2'b10; o.resultsrc = 2'b10; end
      4'd2: begin o.alusrcb = 2'b01; end
      4'd3: begin o.adrsrc = 1; end
      4'd4: begin o.resultsrc = 2'b01; o.regw = 1; end
      4'd5: begin o.adrsrc = 1; o.memw = 1; end
      4'd6: begin o.aluop = 1; end
      4'd7: begin o.alusrcb = 2'b01; o.aluop = 1; end
      4'd8: begin o.regw = 1; end
      4'd9: begin o.alusrca = 2'b10; o.alusrcb = 2'b01; o.resultsrc = 2'b10;
                  o.branch = 1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  // Reference model: the state walk of a whole instruction, by instruction class.
  function automatic void model_seq(input logic [1:0] op, input logic [5:0] funct,
                                    output logic [3:0] seq[$]);
    seq = {};
    case (op)
      2'b01:   seq = funct[0] ? '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4}
                              : '{4'd0, 4'd1, 4'd2, 4'd5};
      2'b00:   seq = funct[5] ? '{4'd0, 4'd1, 4'd7, 4'd8}
                              : '{4'd0, 4'd1, 4'd6, 4'd8};
      2'b10:   seq = '{4'd0, 4'd1, 4'd9};
      default: seq = '{4'd0, 4'd1};
    endcase
  endfunction

  task automatic check_now(input string name, input logic [3:0] s);
    outs_t e;
    e = exp_out(s);
    vectors++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: outputs got %05h want %05h (state got %0d want %0d)",
               name, act, e, act.state, s);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Runs one instruction starting from a negedge in FETCH; checks every cycle.
  task automatic run_instr(input string name, input logic [1:0] op,
                           input logic [5:0] funct, input logic [3:0] seq[$]);
    int wr = 0;
    int pc = 0;
    Op = op;
    Funct = funct;
    foreach (seq[i]) begin
      check_now(name, seq[i]);
      wr += int'(RegW) + int'(MemW) + int'(Branch);
      pc += int'(NextPC);
      @(posedge clk);
      @(negedge clk);
      cyc_cnt++;
    end
    pc_cnt += pc;
    wr_cnt += wr;
    check_int({name, " write-requests"}, wr, (op == 2'b11) ? 0 : 1);
    check_int({name, " nextpc-count"}, pc, 1);
    $display("instr %-10s op=%b funct=%b cycles=%0d", name, op, funct, seq.size());
  endtask

  vec_t       tbl[7];
  logic [3:0] q[$];

  initial begin
    // Directed table: expected walks written out by hand.
    tbl[0] = '{2'b01, 6'b011001, 5, '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4}};
    tbl[1] = '{2'b01, 6'b011000, 4, '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0}};
    tbl[2] = '{2'b00, 6'b001000, 4, '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0}};
    tbl[3] = '{2'b00, 6'b101000, 4, '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0}};
    tbl[4] = '{2'b10, 6'b000000, 3, '{4'd0, 4'd1, 4'd9, 4'd0, 4'd0}};
    tbl[5] = '{2'b11, 6'b111111, 2, '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0}};
    tbl[6] = '{2'b01, 6'b100001, 5, '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4}};

    reset = 1'b1;
    Op = 2'b00;
    Funct = 6'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_now("reset-init", 4'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      q = {};
      for (int k = 0; k < tbl[i].len; k++) q.push_back(tbl[i].st[k]);
      run_instr($sformatf("table%0d", i), tbl[i].op, tbl[i].funct, q);
    end

    // Reset asserted for two cycles in the middle of a load's MEMREAD.
    Op = 2'b01;
    Funct = 6'b011001;
    check_now("rst-seq-fetch", 4'd0);
    @(posedge clk); @(negedge clk);
    check_now("rst-seq-decode", 4'd1);
    @(posedge clk); @(negedge clk);
    check_now("rst-seq-memadr", 4'd2);
    @(posedge clk); @(negedge clk);
    check_now("rst-seq-memread", 4'd3);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    check_now("rst-mid-1", 4'd0);
    @(posedge clk); @(negedge clk);
    check_now("rst-mid-2", 4'd0);
    reset = 1'b0;
    $display("reset mid-MEMREAD checked");

    // Back-to-back stream: load, data-processing, branch, store.
    cyc_cnt = 0;
    pc_cnt = 0;
    wr_cnt = 0;
    model_seq(2'b01, 6'b011001, q); run_instr("b2b-load", 2'b01, 6'b011001, q);
    model_seq(2'b00, 6'b001000, q); run_instr("b2b-dp", 2'b00, 6'b001000, q);
    model_seq(2'b10, 6'b000000, q); run_instr("b2b-br", 2'b10, 6'b000000, q);
    model_seq(2'b01, 6'b011000, q); run_instr("b2b-store", 2'b01, 6'b011000, q);
    check_int("b2b-cycles", cyc_cnt, 16);
    check_int("b2b-pcwrites", pc_cnt, 4);
    check_int("b2b-writes", wr_cnt, 4);
    check_now("b2b-end-fetch", 4'd0);

    // Random instruction stream against the model.
    for (int n = 0; n < 60; n++) begin
      logic [1:0] rop;
      logic [5:0] rfn;
      rop = 2'($urandom_range(0, 3));
      rfn = 6'($urandom);
      model_seq(rop, rfn, q);
      run_instr($sformatf("rand%0d", n), rop, rfn, q);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
